// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader.
// Accepts framed bytes (A5, ADDR, LEN, data..., CSUM) from a host, writes the
// data bytes into a RAM one cycle after acceptance, and holds the CPU in reset
// while loading. The frame is verified with an XOR checksum.
module prog_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              host_valid,
  input  logic [7:0]        host_byte,
  output logic              host_ready,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_write_data,
  output logic              ram_we,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   byte_count
);

  // Byte-accepting states are encoded 0..4 so "accepting" is a simple compare.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  localparam logic [7:0]        HEADER  = 8'hA5;
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0]   BC_ONE  = 1;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [8:0]        rem_q, rem_d;
  logic [7:0]        xsum_q, xsum_d;
  logic [ADDR_W:0]   byte_count_q, byte_count_d;
  logic              load_done_q, load_done_d;
  logic              load_error_q, load_error_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic [DATA_W-1:0] ram_write_data_q, ram_write_data_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              accept;

  // Handshake: ready only in the byte-consuming states while load mode is requested.
  always_comb begin
    host_ready = load_en && (state_q <= S_CSUM) && !rst;
    accept     = host_valid && host_ready;
  end

  // Next-state and datapath update for the frame parser.
  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    rem_d            = rem_q;
    xsum_d           = xsum_q;
    byte_count_d     = byte_count_q;
    load_done_d      = load_done_q;
    load_error_d     = load_error_q;
    ram_we_d         = 1'b0;
    ram_address_d    = ram_address_q;
    ram_write_data_d = ram_write_data_q;
    // State is the pre-edge one, so cpu_hold trails an abort by one cycle.
    cpu_hold_d       = load_en || (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (accept && host_byte == HEADER) begin
          state_d      = S_ADDR;
          byte_count_d = '0;
          load_done_d  = 1'b0;
          load_error_d = 1'b0;
        end
      end
      S_ADDR, S_LEN, S_DATA, S_CSUM: begin
        if (!load_en) begin
          // Abort: a write already queued in ram_we_q still completes.
          state_d      = S_IDLE;
          load_error_d = 1'b1;
        end else if (accept) begin
          case (state_q)
            S_ADDR: begin
              ptr_d   = ADDR_W'(host_byte);
              state_d = S_LEN;
            end
            S_LEN: begin
              rem_d   = (host_byte == 8'd0) ? 9'd256 : {1'b0, host_byte};
              xsum_d  = 8'd0;
              state_d = S_DATA;
            end
            S_DATA: begin
              ram_we_d         = 1'b1;
              ram_address_d    = ptr_q;
              ram_write_data_d = DATA_W'(host_byte);
              xsum_d           = xsum_q ^ host_byte;
              ptr_d            = ptr_q + PTR_ONE;
              byte_count_d     = byte_count_q + BC_ONE;
              rem_d            = rem_q - 9'd1;
              if (rem_q == 9'd1) state_d = S_CSUM;
            end
            default: begin
              if (host_byte == xsum_q) begin
                state_d     = S_DONE;
                load_done_d = 1'b1;
              end else begin
                state_d      = S_ERR;
                load_error_d = 1'b1;
              end
            end
          endcase
        end
      end
      S_DONE, S_ERR: begin
        if (!load_en) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset clears everything, including the RAM-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      ptr_q            <= '0;
      rem_q            <= '0;
      xsum_q           <= '0;
      byte_count_q     <= '0;
      load_done_q      <= 1'b0;
      load_error_q     <= 1'b0;
      ram_we_q         <= 1'b0;
      ram_address_q    <= '0;
      ram_write_data_q <= '0;
      cpu_hold_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      ptr_q            <= ptr_d;
      rem_q            <= rem_d;
      xsum_q           <= xsum_d;
      byte_count_q     <= byte_count_d;
      load_done_q      <= load_done_d;
      load_error_q     <= load_error_d;
      ram_we_q         <= ram_we_d;
      ram_address_q    <= ram_address_d;
      ram_write_data_q <= ram_write_data_d;
      cpu_hold_q       <= cpu_hold_d;
    end
  end

  assign ram_we         = ram_we_q;
  assign ram_address    = ram_address_q;
  assign ram_write_data = ram_write_data_q;
  assign cpu_hold       = cpu_hold_q;
  assign load_done      = load_done_q;
  assign load_error     = load_error_q;
  assign byte_count     = byte_count_q;

endmodule
